addw_pipe: RTL and testbench



---
 rtl/addw_pipe_pkg.sv | 14 +
 rtl/addw_pipe_dly.sv | 35 +++
 rtl/addw_pipe.sv | 107 ++++++++++
 tb/tb_addw_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/addw_pipe_pkg.sv
// Shared definitions for the pipelined add/accumulate unit.
package addw_pipe_pkg;

    // Operation encodings on the op port
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Legal pipeline depth range
    localparam int unsigned STAGES_MIN = 1;
    localparam int unsigned STAGES_MAX = 4;

endpackage

// File: rtl/addw_pipe_dly.sv
// Stallable delay line with synchronous reset; Depth 0 is a plain wire.
module addw_pipe_dly #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (Depth == 0) begin : g_pass
        assign q_o = d_i;
    end else begin : g_regs
        logic [Width-1:0] pipe_q [Depth];

        // Shift one slot per non-stalled edge; reset clears every slot
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < int'(Depth); k++) begin
                    pipe_q[k] <= '0;
                end
            end else if (!stall_i) begin
                pipe_q[0] <= d_i;
                for (int k = 1; k < int'(Depth); k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign q_o = pipe_q[Depth-1];
    end

endmodule

// File: rtl/addw_pipe.sv
// Pipelined add/sub/accumulate unit with optional saturation, predicate and global stall.
module addw_pipe
    import addw_pipe_pkg::*;
#(
    parameter int unsigned width       = 16,
    parameter int unsigned stages      = 2,
    parameter bit          sat         = 1'b0,
    parameter bit          signed_mode = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] i0,
    input  logic [width-1:0] i1,
    input  logic [1:0]       op,
    input  logic             pred,
    input  logic             stall,
    output logic [width-1:0] o0,
    output logic             o0_enable,
    output logic             ovf
);

    if (stages < STAGES_MIN || stages > STAGES_MAX) begin : g_bad_stages
        $error("addw_pipe: stages must be in 1..4");
    end
    if (width < 2) begin : g_bad_width
        $error("addw_pipe: width must be at least 2");
    end

    logic [width-1:0] acc_q, acc_d;
    logic [width-1:0] s1_data_q, s1_data_d;
    logic             s1_en_q, s1_en_d;
    logic             s1_ovf_q, s1_ovf_d;

    logic [width-1:0] opa, opb, sat_val;
    logic [width:0]   ext;
    logic             is_sub, ovf_raw;

    // Stage-1 compute: acc ops use acc as the primary operand and i0 as the addend
    always_comb begin
        is_sub  = (op == OP_SUB);
        opa     = (op == OP_ACC) ? acc_q : i0;
        opb     = (op == OP_ACC) ? i0 : i1;
        ext     = is_sub ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});

        if (signed_mode) begin
            ovf_raw = (is_sub ? (opa[width-1] != opb[width-1]) : (opa[width-1] == opb[width-1]))
                      && (ext[width-1] != opa[width-1]);
            // Clamp direction follows the sign of the primary operand
            sat_val = opa[width-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
        end else begin
            ovf_raw = ext[width];
            sat_val = is_sub ? '0 : '1;
        end

        s1_en_d = pred;
        if (op == OP_LOAD) begin
            s1_data_d = i0;
            s1_ovf_d  = 1'b0;
        end else begin
            s1_data_d = (sat && ovf_raw) ? sat_val : ext[width-1:0];
            s1_ovf_d  = ovf_raw;
        end
    end

    // Accumulator next state: only valid, non-stalled acc/load ops write it
    always_comb begin
        acc_d = acc_q;
        if (pred && !stall && op[1]) begin
            acc_d = s1_data_d;
        end
    end

    // Stage-1 and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q <= '0;
            s1_en_q   <= 1'b0;
            s1_ovf_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            acc_q <= acc_d;
            if (!stall) begin
                s1_data_q <= s1_data_d;
                s1_en_q   <= s1_en_d;
                s1_ovf_q  <= s1_ovf_d;
            end
        end
    end

    logic [width+1:0] dly_out;

    addw_pipe_dly #(
        .Width (width + 2),
        .Depth (stages - 1)
    ) u_dly (
        .clk     (clk),
        .reset   (reset),
        .stall_i (stall),
        .d_i     ({s1_ovf_q, s1_en_q, s1_data_q}),
        .q_o     (dly_out)
    );

    assign o0        = dly_out[width-1:0];
    assign o0_enable = dly_out[width];
    assign ovf       = dly_out[width+1];

endmodule

// File: tb/tb_addw_pipe.sv
// Self-checking bench: four configurations share one stimulus stream, each checked
// against a queue-based arithmetic reference model.
module tb_addw_pipe;
    import addw_pipe_pkg::*;

    localparam int W = 8;
    localparam int NDUT = 4;
    localparam int ST  [NDUT] = '{2, 3, 1, 4};
    localparam int SAT [NDUT] = '{0, 1, 1, 0};
    localparam int SGN [NDUT] = '{1, 1, 0, 0};

    logic         clk = 1'b0;
    logic         reset, pred, stall;
    logic [W-1:0] i0, i1;
    logic [1:0]   op;
    logic [W-1:0] o0_w [NDUT];
    logic         en_w [NDUT];
    logic         ov_w [NDUT];

    always #5 clk = ~clk;

    addw_pipe #(.width(W), .stages(2), .sat(1'b0), .signed_mode(1'b1)) u_d0 (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .op(op), .pred(pred), .stall(stall),
        .o0(o0_w[0]), .o0_enable(en_w[0]), .ovf(ov_w[0]));
    addw_pipe #(.width(W), .stages(3), .sat(1'b1), .signed_mode(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .op(op), .pred(pred), .stall(stall),
        .o0(o0_w[1]), .o0_enable(en_w[1]), .ovf(ov_w[1]));
    addw_pipe #(.width(W), .stages(1), .sat(1'b1), .signed_mode(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .op(op), .pred(pred), .stall(stall),
        .o0(o0_w[2]), .o0_enable(en_w[2]), .ovf(ov_w[2]));
    addw_pipe #(.width(W), .stages(4), .sat(1'b0), .signed_mode(1'b0)) u_d3 (
        .clk(clk), .reset(reset), .i0(i0), .i1(i1), .op(op), .pred(pred), .stall(stall),
        .o0(o0_w[3]), .o0_enable(en_w[3]), .ovf(ov_w[3]));

    typedef struct {
        logic [W-1:0] d;
        logic         en;
        logic         ov;
        logic         known;
    } ent_t;

    ent_t         hist [NDUT][$];
    logic [W-1:0] acc_m [NDUT];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arithmetic: exact integer result, then range check, clamp or wrap
    function automatic void ref_op(input int k, input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] acc,
                                   output logic [W-1:0] res, output logic ov);
        int x, y, t, lo, hi;
        logic [W-1:0] xa, yb;
        if (o == OP_LOAD) begin
            res = a;
            ov  = 1'b0;
            return;
        end
        xa = (o == OP_ACC) ? acc : a;
        yb = (o == OP_ACC) ? a : b;
        if (SGN[k] != 0) begin
            x  = int'($signed(xa));
            y  = int'($signed(yb));
            lo = -(1 << (W - 1));
            hi = (1 << (W - 1)) - 1;
        end else begin
            x  = int'(xa);
            y  = int'(yb);
            lo = 0;
            hi = (1 << W) - 1;
        end
        t  = (o == OP_SUB) ? x - y : x + y;
        ov = (t < lo) || (t > hi);
        if (ov && SAT[k] != 0) t = (t > hi) ? hi : lo;
        res = t[W-1:0];
    endfunction

    // Apply one clock of stimulus, advance the models, then compare every DUT
    task automatic cycle(input logic r, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic p, input logic s);
        ent_t e;
        logic [W-1:0] res;
        logic ov;
        int n;
        reset = r; op = o; i0 = a; i1 = b; pred = p; stall = s;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (r) begin
                hist[k].delete();
                acc_m[k] = '0;
            end else if (!s) begin
                ref_op(k, o, a, b, acc_m[k], res, ov);
                e.d = res; e.en = p; e.ov = ov; e.known = p;
                hist[k].push_back(e);
                if (p && o[1]) acc_m[k] = res;
                if (hist[k].size() > 4) void'(hist[k].pop_front());
            end
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            n = hist[k].size();
            if (n >= ST[k]) begin
                e = hist[k][n - ST[k]];
            end else begin
                e.d = '0; e.en = 1'b0; e.ov = 1'b0; e.known = 1'b1;
            end
            check_eq($sformatf("en[%0d]", k), 16'(en_w[k]), 16'(e.en));
            if (e.known) begin
                check_eq($sformatf("o0[%0d]", k), 16'(o0_w[k]), 16'(e.d));
                check_eq($sformatf("ovf[%0d]", k), 16'(ov_w[k]), 16'(e.ov));
            end
        end
    endtask

    logic [W-1:0] hold_o0;

    initial begin
        reset = 1'b1; op = OP_ADD; i0 = '0; i1 = '0; pred = 1'b0; stall = 1'b0;
        for (int k = 0; k < NDUT; k++) acc_m[k] = '0;

        // Reset overrides pred and stall
        cycle(1'b1, OP_ADD, 8'hAA, 8'h55, 1'b1, 1'b1);
        cycle(1'b1, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("rst_en0", 16'(en_w[0]), 16'd0);

        // Latency: stages=2 result after the second edge
        cycle(1'b0, OP_ADD, 8'h12, 8'h34, 1'b1, 1'b0);
        check_eq("lat_s1_o0", 16'(o0_w[2]), 16'h46);
        cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("lat_s2_o0", 16'(o0_w[0]), 16'h46);
        check_eq("lat_s2_en", 16'(en_w[0]), 16'd1);

        // Signed/unsigned overflow corners
        cycle(1'b0, OP_ADD, 8'h7F, 8'h01, 1'b1, 1'b0);
        cycle(1'b0, OP_SUB, 8'h80, 8'h01, 1'b1, 1'b0);
        check_eq("sgn_wrap_o0", 16'(o0_w[0]), 16'h80);
        check_eq("sgn_wrap_ovf", 16'(ov_w[0]), 16'd1);
        cycle(1'b0, OP_ADD, 8'hF0, 8'h20, 1'b1, 1'b0);
        check_eq("sgn_sat_add", 16'(o0_w[1]), 16'h7F);
        check_eq("uns_sat_add", 16'(o0_w[2]), 16'hFF);
        cycle(1'b0, OP_SUB, 8'h05, 8'h06, 1'b1, 1'b0);
        check_eq("sgn_sat_sub", 16'(o0_w[1]), 16'h80);
        check_eq("uns_sat_sub", 16'(o0_w[2]), 16'h00);
        check_eq("uns_sub_ovf", 16'(ov_w[2]), 16'd1);
        cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("uns_wrap_add", 16'(o0_w[3]), 16'h10);
        cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("uns_wrap_sub", 16'(o0_w[3]), 16'hFF);

        // Accumulate chain with an interleaved invalid acc
        cycle(1'b0, OP_LOAD, 8'h10, 8'hEE, 1'b1, 1'b0);
        check_eq("chain0", 16'(o0_w[2]), 16'h10);
        cycle(1'b0, OP_ACC, 8'h01, 8'hEE, 1'b1, 1'b0);
        check_eq("chain1", 16'(o0_w[2]), 16'h11);
        cycle(1'b0, OP_ACC, 8'h02, 8'hEE, 1'b1, 1'b0);
        check_eq("chain2", 16'(o0_w[2]), 16'h13);
        cycle(1'b0, OP_ACC, 8'h40, 8'hEE, 1'b0, 1'b0);
        check_eq("chain_nopred", 16'(en_w[2]), 16'd0);
        cycle(1'b0, OP_ACC, 8'h03, 8'hEE, 1'b1, 1'b0);
        check_eq("chain3", 16'(o0_w[2]), 16'h16);

        // Stall with garbage inputs: outputs frozen, nothing leaks in
        cycle(1'b0, OP_ADD, 8'h21, 8'h03, 1'b1, 1'b0);
        hold_o0 = o0_w[1];
        cycle(1'b0, OP_LOAD, 8'hC3, 8'h5A, 1'b1, 1'b1);
        check_eq("stall_hold", 16'(o0_w[1]), 16'(hold_o0));
        cycle(1'b0, OP_ACC, 8'h77, 8'h5A, 1'b1, 1'b1);
        check_eq("stall_hold2", 16'(o0_w[1]), 16'(hold_o0));
        cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("stall_emerge", 16'(o0_w[1]), 16'h24);
        check_eq("stall_emerge_en", 16'(en_w[1]), 16'd1);

        // Reset mid-flight drops everything in the stages=4 pipe and clears acc
        cycle(1'b0, OP_ADD, 8'h01, 8'h01, 1'b1, 1'b0);
        cycle(1'b0, OP_ACC, 8'h02, 8'h01, 1'b1, 1'b0);
        cycle(1'b0, OP_SUB, 8'h09, 8'h01, 1'b1, 1'b0);
        cycle(1'b1, OP_ADD, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, 1'b0);
            check_eq("rst_flush_en", 16'(en_w[3]), 16'd0);
        end
        cycle(1'b0, OP_ACC, 8'h05, 8'h00, 1'b1, 1'b0);
        check_eq("rst_acc_clr", 16'(o0_w[2]), 16'h05);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 59) == 0, 2'($urandom_range(0, 3)), 8'($urandom),
                  8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
